rsa_exp_arbiter: RTL

RSA_EXP_ARBITER -- requirements
Module: rsa_exp_arbiter

---
 rtl/rsa_exp_arbiter_pkg.sv | 29 ++
 rtl/rsa_exp_arbiter_rr_arb2.sv | 32 +++
 rtl/rsa_exp_arbiter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/rsa_exp_arbiter_pkg.sv
// Shared definitions for the RSA exponentiation arbiter: operand width,
// FSM state encoding and the default engine timeout.
`ifndef BITS
`define BITS 32
`endif
`ifndef LOG_BITS
`define LOG_BITS 5
`endif
`ifndef RSA_EXP_TIMEOUT_DEFAULT
`define RSA_EXP_TIMEOUT_DEFAULT (4 * `BITS * (`BITS + 6))
`endif

package rsa_exp_arbiter_pkg;

    localparam int BITS            = `BITS;
    localparam int TIMEOUT_DEFAULT = `RSA_EXP_TIMEOUT_DEFAULT;

    // Number of cycles the engine reset is held after a timeout.
    localparam int ABORT_CYCLES    = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_BUSY    = 3'd2,
        ST_RESPOND = 3'd3,
        ST_ABORT   = 3'd4
    } state_t;

endpackage

// File: rtl/rsa_exp_arbiter_rr_arb2.sv
// Two-way round-robin grant. The pointer names the port with priority;
// after a granted handshake priority moves to the other port.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic prio;

    // One-hot grant: the priority port if it requests, else the other one.
    always_comb begin
        grant = 2'b00;
        if (req[prio]) begin
            grant[prio] = 1'b1;
        end else if (req[~prio]) begin
            grant[~prio] = 1'b1;
        end
    end

    // After a handshake the port that was not granted takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio <= 1'b0;
        end else if (advance) begin
            prio <= grant[0];
        end
    end

endmodule

// File: rtl/rsa_exp_arbiter.sv
// Arbitrates two requesters onto one shared mod_exp engine, with a job
// timeout that resets the engine and returns an error response.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | accepting a job from the round-robin winner
//   ISSUE   | one-cycle start pulse to the engine, timeout counter cleared
//   BUSY    | waiting for eng_out_valid, counting towards the timeout
//   ABORT   | engine held in reset, result forced to 0 with err
//   RESPOND | result offered to the winning requester until accepted
module rsa_exp_arbiter
    import rsa_exp_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [BITS-1:0] req0_m,
    input  logic [BITS-1:0] req0_e,
    input  logic [BITS-1:0] req0_n,
    input  logic [BITS-1:0] req0_r2,

    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [BITS-1:0] req1_m,
    input  logic [BITS-1:0] req1_e,
    input  logic [BITS-1:0] req1_n,
    input  logic [BITS-1:0] req1_r2,

    output logic            rsp0_valid,
    input  logic            rsp0_ready,
    output logic [BITS-1:0] rsp0_data,
    output logic            rsp0_err,

    output logic            rsp1_valid,
    input  logic            rsp1_ready,
    output logic [BITS-1:0] rsp1_data,
    output logic            rsp1_err,

    output logic [BITS-1:0] eng_m,
    output logic [BITS-1:0] eng_e,
    output logic [BITS-1:0] eng_n,
    output logic [BITS-1:0] eng_r2,
    output logic            eng_in_valid,
    output logic            eng_rst,
    input  logic [BITS-1:0] eng_out,
    input  logic            eng_out_valid,

    output logic            busy
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] ABORT_LAST   = CNT_W'(ABORT_CYCLES - 1);

    state_t           state;
    state_t           state_nx;
    logic [1:0]       req_valid_v;
    logic [1:0]       req_ready_v;
    logic [1:0]       rsp_ready_v;
    logic [1:0]       rsp_valid_v;
    logic [1:0]       grant;
    logic             hs;
    logic             win;
    logic             rst_hold;
    logic             abort_rst;
    logic [CNT_W-1:0] cnt;
    logic [BITS-1:0]  data_q;
    logic             err_q;

    assign req_valid_v = {req1_valid, req0_valid};
    assign rsp_ready_v = {rsp1_ready, rsp0_ready};

    // rst_hold keeps the port closed until the first edge after reset.
    assign req_ready_v = (state == ST_IDLE && !rst_hold) ? grant : 2'b00;
    assign hs          = |(req_ready_v & req_valid_v);

    assign req0_ready  = req_ready_v[0];
    assign req1_ready  = req_ready_v[1];
    assign rsp0_valid  = rsp_valid_v[0];
    assign rsp1_valid  = rsp_valid_v[1];
    assign rsp0_data   = data_q;
    assign rsp1_data   = data_q;
    assign rsp0_err    = err_q;
    assign rsp1_err    = err_q;
    assign eng_rst     = rst_hold | abort_rst;
    assign busy        = (state != ST_IDLE);

    rr_arb2 u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid_v),
        .advance (hs),
        .grant   (grant)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Engine reset is asserted asynchronously and released on the first edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_hold <= 1'b1;
        end else begin
            rst_hold <= 1'b0;
        end
    end

    // Next state and per-state outputs.
    always_comb begin
        state_nx     = state;
        eng_in_valid = 1'b0;
        abort_rst    = 1'b0;
        rsp_valid_v  = 2'b00;
        case (state)
            ST_IDLE: begin
                if (hs) begin
                    state_nx = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                eng_in_valid = 1'b1;
                state_nx     = ST_BUSY;
            end
            ST_BUSY: begin
                // Completion in the timeout cycle still counts as a result.
                if (eng_out_valid) begin
                    state_nx = ST_RESPOND;
                end else if (cnt == TIMEOUT_LAST) begin
                    state_nx = ST_ABORT;
                end
            end
            ST_ABORT: begin
                abort_rst = 1'b1;
                if (cnt == ABORT_LAST) begin
                    state_nx = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                rsp_valid_v[win] = 1'b1;
                if (rsp_ready_v[win]) begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Operands and winner id are captured at the request handshake only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win    <= 1'b0;
            eng_m  <= '0;
            eng_e  <= '0;
            eng_n  <= '0;
            eng_r2 <= '0;
        end else if (hs) begin
            win    <= grant[1];
            eng_m  <= grant[1] ? req1_m  : req0_m;
            eng_e  <= grant[1] ? req1_e  : req0_e;
            eng_n  <= grant[1] ? req1_n  : req0_n;
            eng_r2 <= grant[1] ? req1_r2 : req0_r2;
        end
    end

    // Shared cycle counter: job runtime in BUSY, reset length in ABORT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state == ST_ISSUE) begin
            cnt <= '0;
        end else if (state == ST_BUSY) begin
            cnt <= (state_nx == ST_ABORT) ? '0 : cnt + 1'b1;
        end else if (state == ST_ABORT) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Result capture; engine output is only looked at while BUSY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            err_q  <= 1'b0;
        end else if (state == ST_BUSY && eng_out_valid) begin
            data_q <= eng_out;
            err_q  <= 1'b0;
        end else if (state == ST_ABORT) begin
            data_q <= '0;
            err_q  <= 1'b1;
        end
    end

endmodule
